hour_chime_alarm: RTL
=====================

HOUR_CHIME_ALARM -- requirements
Module: hour_chime_alarm

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 1000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter TONE_LO_HZ, default 250, giving the pre-chime tone frequency.
REQ-003 SHALL have parameter TONE_HI_HZ, default 500, giving the on-the-hour and alarm tone frequency.
REQ-004 SHALL have parameter ALARM_SECS, default 60, giving the maximum alarm ring time in seconds.
REQ-005 SHALL have port clk, input, 1 bit: system clock (CP2); all logic is on the rising edge.
REQ-006 SHALL have port CLR_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports hour [4:0] (0-23), minute [5:0] (0-59) and second [5:0] (0-59), all inputs from the time counter, synchronous to clk.
REQ-008 SHALL have port alarm_en, input, 1 bit: level that arms the alarm.
REQ-009 SHALL have ports al_h_inc and al_m_inc, inputs, 1 bit each: one-cycle, debounced pulses that step the alarm hour and minute.
REQ-010 SHALL have port stop, input, 1 bit: one-cycle pulse that silences a ringing alarm.
REQ-011 SHALL have port speaker, output, 1 bit: square-wave tone that drives the LG1 dp/SPEAKER pin.
REQ-012 SHALL have ports al_hour [4:0] and al_min [5:0], outputs: the stored alarm time.
REQ-013 SHALL have ports chime_on and alarm_on, outputs, 1 bit each: registered activity flags.

Function
REQ-014 SHALL generate a one-cycle internal sec_tick whenever second differs from its registered copy.
REQ-015 SHALL assert chime_lo while minute==59 and second is one of 50, 52, 54, 56, 58; SHALL assert chime_hi while minute==0 and second==0; chime_on = chime_lo | chime_hi, registered, one cycle of latency.
REQ-016 SHALL implement the alarm state machine A_IDLE, A_RING:
  - A_IDLE->A_RING on sec_tick when alarm_en=1, hour==al_hour, minute==al_min and second==0.
  - A_RING->A_IDLE on stop, on alarm_en=0, or when the ring-seconds counter reaches ALARM_SECS.
REQ-017 SHALL count sec_tick pulses in A_RING with a ring counter of ceil(log2(ALARM_SECS+1)) bits, cleared on entry to A_RING.
REQ-018 SHALL set alarm_on = (state==A_RING), registered.
REQ-019 SHALL make the alarm sound gated: tone during even seconds (second[0]==0) and silence during odd seconds.
REQ-020 SHALL select the tone with priority chime_hi > chime_lo > audible alarm > silent.
REQ-021 SHALL toggle speaker every CLK_FREQ/(2*TONE_x_HZ) cycles using an integer-division half-period counter.
REQ-022 SHALL clear the half-period counter and drive speaker=0 whenever the selected tone changes or goes silent.
REQ-023 SHALL step al_min modulo 60 on al_m_inc (59->0) and al_hour modulo 24 on al_h_inc (23->0); the two steps are independent, and simultaneous pulses step both.
REQ-024 SHALL NOT carry an al_min wrap into al_hour.
REQ-025 SHALL let alarm-time edits during A_RING change only the stored time, not the ringing.
REQ-026 SHALL treat stop in A_IDLE as a no-op.
REQ-027 SHALL NOT retrigger the alarm after it has been stopped within the same minute; only a fresh second==0 match triggers it.
REQ-028 SHALL trigger on any time jump caused by adjustment that lands exactly on a match.
REQ-029 SHALL, when the alarm coincides with hh:00:00, sound the high chime for that second and keep the alarm in A_RING.

Reset
REQ-030 SHALL, while CLR_n=0, set: speaker=0, chime_on=0, alarm_on=0, state=A_IDLE, all counters=0, al_hour=7, al_min=0, and the registered second copy=0.
REQ-031 SHALL silence the output immediately on CLR_n assertion mid-tone; the first sec_tick after release SHALL be ignored for alarm triggering.

Configuration
REQ-032 SHALL include the alarm feature (REQ-016..REQ-019, REQ-023..REQ-029) only when macro HOUR_CHIME_ALARM_EN is defined.
REQ-033 SHALL, when HOUR_CHIME_ALARM_EN is undefined, keep only the hourly chime and tie alarm_on=0, al_hour=7 and al_min=0; alarm inputs SHALL be ignored.

Verification
REQ-034 SHALL cover this scenario: sweep 12:59:49->13:00:01 at CLK_FREQ=1000 -> speaker at 250 Hz (2 ms half-period) in seconds 50/52/54/56/58, silent in odd seconds, 500 Hz at 13:00:00, chime_on=0 at 13:00:01.
REQ-035 SHALL cover this scenario: alarm_en=1 with alarm 07:00, time 06:59:59->07:00:00 -> alarm_on=1, 500 Hz tone in even seconds; 60 ticks later alarm_on=0.
REQ-036 SHALL cover this scenario: a stop pulse at 07:00:05 -> alarm_on=0 next cycle, speaker=0, no retrigger through 07:00:59.
REQ-037 SHALL cover this scenario: 24 al_h_inc pulses from 23 -> 23,0,...,23, and al_m_inc at 59 -> 0 with al_hour unchanged.
REQ-038 SHALL cover this scenario: alarm set to 08:00 with the clock at 08:00:00 -> high chime wins for that second, and alarm_on=1 persists into 08:00:02 with tone.
REQ-039 SHALL cover this scenario: CLR_n pulsed low mid-tone -> speaker=0 asynchronously, al_hour=7, al_min=0, with the build rerun without HOUR_CHIME_ALARM_EN to confirm alarm_on stays 0.

Source files
------------

// File: rtl/hour_chime_alarm.sv
// Hourly chime (low pre-chime at xx:59:50..58, high tone at xx:00:00) with a
// speaker tone generator; the alarm clock feature is built only with HOUR_CHIME_ALARM_EN.
module hour_chime_alarm #(
  parameter int unsigned CLK_FREQ   = 1000,
  parameter int unsigned TONE_LO_HZ = 250,
  parameter int unsigned TONE_HI_HZ = 500,
  parameter int unsigned ALARM_SECS = 60
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       alarm_en,
  input  logic       al_h_inc,
  input  logic       al_m_inc,
  input  logic       stop,
  output logic       speaker,
  output logic [4:0] al_hour,
  output logic [5:0] al_min,
  output logic       chime_on,
  output logic       alarm_on
);

  localparam int unsigned HALF_LO_RAW = CLK_FREQ / (2 * TONE_LO_HZ);
  localparam int unsigned HALF_HI_RAW = CLK_FREQ / (2 * TONE_HI_HZ);
  // A half-period below one cycle is clamped so the counter compare stays valid.
  localparam int unsigned HALF_LO     = (HALF_LO_RAW == 0) ? 1 : HALF_LO_RAW;
  localparam int unsigned HALF_HI     = (HALF_HI_RAW == 0) ? 1 : HALF_HI_RAW;
  localparam int unsigned HALF_MAX    = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
  localparam int unsigned HCNT_W      = $clog2(HALF_MAX + 1);

  typedef enum logic [1:0] {TONE_OFF, TONE_LO, TONE_HI} tone_e;

  logic [5:0]        sec_q;
  logic              sec_tick;
  logic              chime_lo;
  logic              chime_hi;
  logic              alarm_audible;
  tone_e             tone_sel;
  tone_e             tone_q;
  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] half_lim;

  // Second-change detector
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) sec_q <= '0;
    else        sec_q <= second;
  end

  assign sec_tick = (second != sec_q);

  assign chime_lo = (minute == 6'd59) && (second >= 6'd50) && (second <= 6'd58) && !second[0];
  assign chime_hi = (minute == 6'd0) && (second == 6'd0);

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) chime_on <= 1'b0;
    else        chime_on <= chime_lo | chime_hi;
  end

`ifdef HOUR_CHIME_ALARM_EN
  localparam int unsigned RING_W = $clog2(ALARM_SECS + 1);

  typedef enum logic {A_IDLE, A_RING} a_state_e;

  a_state_e          state_q;
  a_state_e          state_d;
  logic [RING_W-1:0] ring_q;
  logic [RING_W-1:0] ring_d;
  logic              tick_seen_q;
  logic              match;

  // The very first tick after reset never triggers the alarm.
  assign match = sec_tick && tick_seen_q && alarm_en && (hour == al_hour) &&
                 (minute == al_min) && (second == 6'd0);

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q     <= A_IDLE;
      ring_q      <= '0;
      alarm_on    <= 1'b0;
      tick_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_q      <= ring_d;
      alarm_on    <= (state_d == A_RING);
      tick_seen_q <= tick_seen_q | sec_tick;
    end
  end

  // Alarm next-state and ring-seconds counter
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    case (state_q)
      A_IDLE: begin
        if (match) begin
          state_d = A_RING;
          ring_d  = '0;
        end
      end
      A_RING: begin
        if (stop || !alarm_en || (ring_q == RING_W'(ALARM_SECS))) begin
          state_d = A_IDLE;
          ring_d  = '0;
        end else if (sec_tick) begin
          ring_d = ring_q + RING_W'(1);
        end
      end
      default: begin
        state_d = A_IDLE;
        ring_d  = '0;
      end
    endcase
  end

  // Alarm time setting; hour and minute wrap independently.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      al_hour <= 5'd7;
      al_min  <= 6'd0;
    end else begin
      if (al_h_inc) al_hour <= (al_hour == 5'd23) ? 5'd0 : al_hour + 5'd1;
      if (al_m_inc) al_min  <= (al_min == 6'd59) ? 6'd0 : al_min + 6'd1;
    end
  end

  assign alarm_audible = (state_q == A_RING) && !second[0];
`else
  logic unused_alarm_inputs;

  assign unused_alarm_inputs = ^{hour, alarm_en, al_h_inc, al_m_inc, stop, sec_tick};
  assign alarm_on            = 1'b0;
  assign al_hour             = 5'd7;
  assign al_min              = 6'd0;
  assign alarm_audible       = 1'b0;
`endif

  // Tone priority: on-the-hour chime, pre-chime, alarm, silence
  always_comb begin
    tone_sel = TONE_OFF;
    if (chime_hi)           tone_sel = TONE_HI;
    else if (chime_lo)      tone_sel = TONE_LO;
    else if (alarm_audible) tone_sel = TONE_HI;
  end

  assign half_lim = (tone_sel == TONE_HI) ? HCNT_W'(HALF_HI - 1) : HCNT_W'(HALF_LO - 1);

  // Half-period counter restarts from a low speaker on every tone change.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      tone_q  <= TONE_OFF;
      hcnt_q  <= '0;
      speaker <= 1'b0;
    end else begin
      tone_q <= tone_sel;
      if ((tone_sel != tone_q) || (tone_sel == TONE_OFF)) begin
        hcnt_q  <= '0;
        speaker <= 1'b0;
      end else if (hcnt_q == half_lim) begin
        hcnt_q  <= '0;
        speaker <= ~speaker;
      end else begin
        hcnt_q <= hcnt_q + HCNT_W'(1);
      end
    end
  end

endmodule
